// File: rtl/ahb_slave_mem_if.sv
`default_nettype none
// ============================================================================
// ahb_slave_mem_if : AHB-Lite bus bundle between a master/decoder and ahb_slave_mem
// Revision 1.0
// ============================================================================
interface ahb_slave_mem_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                  hsel;
  logic                  hready_in;
  logic [1:0]            htrans;
  logic [2:0]            hburst;
  logic [2:0]            hsize;
  logic                  hwrite;
  logic [ADDR_WIDTH-1:0] haddr;
  logic [DATA_WIDTH-1:0] hwdata;
  logic                  hready;
  logic [1:0]            hresp;
  logic [DATA_WIDTH-1:0] hrdata;

  modport master (
    output hsel, hready_in, htrans, hburst, hsize, hwrite, haddr, hwdata,
    input  hready, hresp, hrdata
  );

  modport slave (
    input  hsel, hready_in, htrans, hburst, hsize, hwrite, haddr, hwdata,
    output hready, hresp, hrdata
  );
endinterface
`default_nettype wire

// File: rtl/ahb_slave_mem.sv
`default_nettype none
// ============================================================================
// ahb_slave_mem : AHB-Lite responder backed by a word-organised register memory.
// Optional wait states enabled by defining AHB_SLV_WAIT_EN.
// Revision 1.0
// ============================================================================
module ahb_slave_mem #(
  parameter int                    ADDR_WIDTH  = 32,
  parameter int                    DATA_WIDTH  = 32,
  parameter int                    MEM_DEPTH   = 256,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = '0,
  parameter int                    WAIT_CYCLES = 2
) (
  input  wire logic      hclk,
  input  wire logic      hresetn,
  ahb_slave_mem_if.slave s_ahb
);

  localparam int                  c_idx_w = $clog2(MEM_DEPTH);
  localparam logic [ADDR_WIDTH:0] c_span  = (ADDR_WIDTH+1)'(4 * MEM_DEPTH);
  localparam logic [1:0]          c_okay  = 2'b00;
  localparam logic [1:0]          c_error = 2'b01;

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_ERR1, S_ERR2} state_t;

  state_t                r_state;
  logic                  r_hready;
  logic [1:0]            r_hresp;
  logic [DATA_WIDTH-1:0] r_hrdata;
  logic [c_idx_w-1:0]    r_idx;
  logic [3:0]            r_be;
  logic                  r_write;
  logic [DATA_WIDTH-1:0] r_mem [MEM_DEPTH];

  logic                  w_borrow;
  logic [ADDR_WIDTH-1:0] w_off;
  logic                  w_err;
  logic [c_idx_w-1:0]    w_idx;
  logic [3:0]            w_be;
  logic                  w_wait_zero;
  logic                  w_last_wait;
  logic                  w_slot;
  logic                  w_accept;
  logic                  w_commit;
  logic [DATA_WIDTH-1:0] w_merged;
  logic [DATA_WIDTH-1:0] w_rd_word;
  logic                  w_unused;

  assign {w_borrow, w_off} = {1'b0, s_ahb.haddr} - {1'b0, BASE_ADDR};
  assign w_idx = w_off[c_idx_w+1:2];
  assign w_err = w_borrow || ({1'b0, w_off} >= c_span) || (s_ahb.hsize > 3'b010)
              || ((s_ahb.hsize == 3'b001) && s_ahb.haddr[0])
              || ((s_ahb.hsize == 3'b010) && (s_ahb.haddr[1:0] != 2'b00));
  assign w_unused = ^{s_ahb.hburst, s_ahb.htrans[0]};

  always_comb begin
    w_be = 4'b1111;
    case (s_ahb.hsize)
      3'b000:  w_be = 4'b0001 << s_ahb.haddr[1:0];
      3'b001:  w_be = s_ahb.haddr[1] ? 4'b1100 : 4'b0011;
      default: w_be = 4'b1111;
    endcase
  end

`ifdef AHB_SLV_WAIT_EN
  localparam logic [3:0] c_wait = 4'(WAIT_CYCLES);
  logic [3:0] r_wcnt;

  always_ff @(posedge hclk) begin
    if (!hresetn)
      r_wcnt <= '0;
    else if (w_accept && !w_err)
      r_wcnt <= c_wait;
    else if (r_state == S_DATA && r_wcnt != 4'd0)
      r_wcnt <= r_wcnt - 4'd1;
  end

  assign w_wait_zero = (r_wcnt == 4'd0);
  assign w_last_wait = (r_wcnt == 4'd1);
`else
  localparam logic [3:0] c_wait = 4'd0;
  localparam int         c_unused_wait_cycles = WAIT_CYCLES;
  assign w_wait_zero = 1'b1;
  assign w_last_wait = 1'b0;
`endif

  // A new address phase can only be taken when no data phase is stalling the bus.
  assign w_slot   = (r_state == S_IDLE) || (r_state == S_ERR2)
                 || ((r_state == S_DATA) && w_wait_zero);
  assign w_accept = w_slot && s_ahb.hsel && s_ahb.hready_in && s_ahb.htrans[1];
  assign w_commit = (r_state == S_DATA) && w_wait_zero && r_write;

  always_comb begin
    w_merged = r_mem[r_idx];
    for (int b = 0; b < 4; b++)
      if (r_be[b]) w_merged[8*b +: 8] = s_ahb.hwdata[8*b +: 8];
  end

  // Forward the word being committed this cycle to a read of the same index.
  assign w_rd_word = (w_commit && (r_idx == w_idx)) ? w_merged : r_mem[w_idx];

  always_ff @(posedge hclk) begin
    if (hresetn && w_commit)
      r_mem[r_idx] <= w_merged;
  end

  always_ff @(posedge hclk) begin
    if (!hresetn) begin
      r_state  <= S_IDLE;
      r_hready <= 1'b1;
      r_hresp  <= c_okay;
      r_hrdata <= '0;
      r_idx    <= '0;
      r_be     <= '0;
      r_write  <= 1'b0;
    end else begin
      case (r_state)
        S_DATA: if (!w_wait_zero) begin
          r_hready <= w_last_wait;
          r_hresp  <= c_okay;
        end
        S_ERR1: begin
          r_state  <= S_ERR2;
          r_hready <= 1'b1;
          r_hresp  <= c_error;
        end
        default: ;
      endcase
      if (w_slot) begin
        if (w_accept && w_err) begin
          r_state  <= S_ERR1;
          r_hready <= 1'b0;
          r_hresp  <= c_error;
          r_write  <= 1'b0;
        end else if (w_accept) begin
          r_state  <= S_DATA;
          r_hready <= (c_wait == 4'd0);
          r_hresp  <= c_okay;
          r_idx    <= w_idx;
          r_be     <= w_be;
          r_write  <= s_ahb.hwrite;
          if (!s_ahb.hwrite) r_hrdata <= w_rd_word;
        end else begin
          r_state  <= S_IDLE;
          r_hready <= 1'b1;
          r_hresp  <= c_okay;
          r_write  <= 1'b0;
        end
      end
    end
  end

  assign s_ahb.hready = r_hready;
  assign s_ahb.hresp  = r_hresp;
  assign s_ahb.hrdata = r_hrdata;

endmodule
`default_nettype wire

// File: tb/tb_ahb_slave_mem.sv
`default_nettype none
// ============================================================================
// tb_ahb_slave_mem : directed AHB-Lite vectors with a queue-based response scoreboard
// Revision 1.0
// ============================================================================
module tb_ahb_slave_mem;
  localparam int AW = 32, DW = 32, DEPTH = 256, WAITS = 2;
`ifdef AHB_SLV_WAIT_EN
  localparam int EXP_WAIT = WAITS;
`else
  localparam int EXP_WAIT = 0;
`endif

  typedef struct {
    int          id;
    bit          rd;
    bit          err;
    logic [31:0] data;
  } exp_t;

  logic hclk = 1'b0;
  logic hresetn = 1'b0;
  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_bad = 0;
  int   next_id = 0;

  always #5 hclk = ~hclk;

  ahb_slave_mem_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();
  assign bus.hready_in = bus.hready;

  ahb_slave_mem #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MEM_DEPTH(DEPTH),
    .BASE_ADDR(32'h0000_0000), .WAIT_CYCLES(WAITS)
  ) dut (
    .hclk(hclk), .hresetn(hresetn), .s_ahb(bus)
  );

  task automatic check(input string nm, input int id, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s (xfer %0d): got 0x%08h, required 0x%08h", nm, id, act, req);
    end
  endtask

  // Issue one transfer; returns 1 time unit after its address phase was accepted.
  task automatic xfer(input bit wr, input logic [31:0] a, input logic [2:0] sz,
                      input logic [31:0] wd, input logic [31:0] rd_exp, input bit err);
    exp_t e;
    int   guard;
    e.id = next_id; e.rd = !wr; e.err = err; e.data = rd_exp;
    next_id++;
    exp_q.push_back(e);
    bus.hsel = 1'b1; bus.htrans = 2'b10; bus.hwrite = wr;
    bus.haddr = a; bus.hsize = sz; bus.hburst = 3'b000;
    guard = 0;
    @(negedge hclk);
    while (bus.hready !== 1'b1 && guard < 50) begin
      guard++;
      @(negedge hclk);
    end
    if (guard >= 50) begin
      n_vec++; n_bad++;
      $display("FAIL accept_timeout (xfer %0d): hready stayed low", e.id);
    end
    @(posedge hclk); #1;
    bus.hwdata = wd;
    bus.hsel = 1'b0; bus.htrans = 2'b00;
  endtask

  task automatic idle(input int n);
    bus.hsel = 1'b0; bus.htrans = 2'b00;
    repeat (n) @(posedge hclk);
    #1;
  endtask

  task automatic check_quiet(input string nm, input logic [31:0] rdata);
    check({nm, "_hready"}, -1, 32'(bus.hready), 32'd1);
    check({nm, "_hresp"},  -1, 32'(bus.hresp),  32'd0);
    check({nm, "_hrdata"}, -1, bus.hrdata, rdata);
  endtask

  // Monitor: follows data phases on the bus and scores each completion.
  bit   mon_act = 1'b0;
  bit   mon_wbad = 1'b0;
  int   mon_waits = 0;
  exp_t mon_e;

  always @(negedge hclk) begin
    if (!hresetn) begin
      if (mon_act && exp_q.size() > 0) mon_e = exp_q.pop_front();
      mon_act = 1'b0;
    end else begin
      if (mon_act) begin
        if (bus.hready !== 1'b1) begin
          mon_waits++;
          if (exp_q.size() > 0 && bus.hresp !== (exp_q[0].err ? 2'b01 : 2'b00)) mon_wbad = 1'b1;
        end else begin
          mon_act = 1'b0;
          if (exp_q.size() == 0) begin
            n_vec++; n_bad++;
            $display("FAIL unexpected_phase: data phase with empty scoreboard");
          end else begin
            mon_e = exp_q.pop_front();
            check("hresp", mon_e.id, 32'(bus.hresp), mon_e.err ? 32'd1 : 32'd0);
            check("wait_cycles", mon_e.id, 32'(mon_waits), mon_e.err ? 32'd1 : 32'(EXP_WAIT));
            check("wait_hresp", mon_e.id, 32'(mon_wbad), 32'd0);
            if (mon_e.rd && !mon_e.err) check("hrdata", mon_e.id, bus.hrdata, mon_e.data);
          end
        end
      end
      if (bus.hsel && bus.hready_in && bus.htrans[1]) begin
        mon_act = 1'b1; mon_waits = 0; mon_wbad = 1'b0;
      end
    end
  end

  initial begin
    int guard;
    bus.hsel = 1'b0; bus.htrans = 2'b00; bus.hburst = 3'b000; bus.hsize = 3'b000;
    bus.hwrite = 1'b0; bus.haddr = '0; bus.hwdata = '0;
    repeat (2) @(posedge hclk);
    #1 hresetn = 1'b1;
    @(negedge hclk);
    check_quiet("reset", 32'h0);
    repeat (5) @(negedge hclk);
    check_quiet("idle", 32'h0);
    @(posedge hclk); #1;

    // word write, then forwarded read
    xfer(1, 32'h10, 3'b010, 32'hDEADBEEF, 32'h0, 0);
    xfer(0, 32'h10, 3'b010, 32'h0, 32'hDEADBEEF, 0);
    idle(2);

    // sub-word writes with forwarded and stored reads
    xfer(1, 32'h20, 3'b010, 32'h00000000, 32'h0, 0);
    xfer(1, 32'h21, 3'b000, 32'h0000AA00, 32'h0, 0);
    xfer(1, 32'h22, 3'b001, 32'h12340000, 32'h0, 0);
    xfer(0, 32'h20, 3'b010, 32'h0, 32'h1234AA00, 0);
    idle(1);
    xfer(0, 32'h20, 3'b010, 32'h0, 32'h1234AA00, 0);
    xfer(1, 32'h23, 3'b000, 32'h77000000, 32'h0, 0);
    xfer(0, 32'h20, 3'b010, 32'h0, 32'h7734AA00, 0);
    idle(2);

    // error responses leave memory untouched (0x400 also aliases word 0)
    xfer(1, 32'h00,  3'b010, 32'hCAFEF00D, 32'h0, 0);
    xfer(1, 32'h02,  3'b010, 32'hFFFFFFFF, 32'h0, 1);
    xfer(1, 32'h400, 3'b010, 32'h11111111, 32'h0, 1);
    xfer(0, 32'h400, 3'b010, 32'h0, 32'h0, 1);
    xfer(1, 32'h01,  3'b001, 32'h22222222, 32'h0, 1);
    xfer(1, 32'h00,  3'b011, 32'h33333333, 32'h0, 1);
    xfer(0, 32'h00,  3'b010, 32'h0, 32'hCAFEF00D, 0);
    idle(2);

    // BUSY and unselected NONSEQ produce no data phase
    bus.hsel = 1'b1; bus.htrans = 2'b01; bus.hwrite = 1'b1; bus.haddr = 32'h00; bus.hsize = 3'b010;
    repeat (2) begin @(negedge hclk); check_quiet("busy", 32'hCAFEF00D); end
    bus.hsel = 1'b0; bus.htrans = 2'b10;
    repeat (2) begin @(negedge hclk); check_quiet("unsel", 32'hCAFEF00D); end
    @(posedge hclk); #1;
    idle(1);

    // isolated read: wait states apply when enabled
    xfer(0, 32'h10, 3'b010, 32'h0, 32'hDEADBEEF, 0);
    idle(4);

    // reset during a write data phase aborts the write
    xfer(1, 32'h30, 3'b010, 32'h11223344, 32'h0, 0);
    idle(3);
    xfer(1, 32'h30, 3'b010, 32'h55667788, 32'h0, 0);
    hresetn = 1'b0;
    repeat (2) @(posedge hclk);
    #1 hresetn = 1'b1;
    @(negedge hclk);
    check_quiet("midreset", 32'h0);
    @(posedge hclk); #1;
    xfer(0, 32'h30, 3'b010, 32'h0, 32'h11223344, 0);
    idle(4);

    guard = 0;
    while (exp_q.size() > 0 && guard < 100) begin
      guard++;
      @(posedge hclk);
    end
    check("scoreboard_drained", -1, 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/ahb_slave_mem.md
Name: ahb_slave_mem

Overview:
- AHB-Lite responder (slave end of the AHB bus) backed by a word-organised register memory.
- Sits behind the address filter as the default target; complements the bus master agent.
- Handles the pipelined address/data phases, byte/halfword/word writes and two-cycle ERROR responses.
- Optionally inserts a fixed number of wait states per transfer.

Parameters:
- ADDR_WIDTH, 32, haddr width
- DATA_WIDTH, 32, hwdata/hrdata width (fixed 32 in this revision)
- MEM_DEPTH, 256, number of 32-bit words
- BASE_ADDR, 32'h0000_0000, byte address of word 0
- WAIT_CYCLES, 2, wait states per data phase when AHB_SLV_WAIT_EN is defined (0..15)

Ports:
- hclk  input  1  bus clock, all logic on posedge
- hresetn  input  1  synchronous active-low reset
- hsel  input  1  slave select from decoder
- hready_in  input  1  system hready (previous data phase done)
- htrans  input  2  00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ
- hburst  input  3  burst type (ignored; accepted for protocol completeness)
- hsize  input  3  000 byte, 001 half, 010 word
- hwrite  input  1  1 = write
- haddr  input  ADDR_WIDTH  byte address
- hwdata  input  DATA_WIDTH  write data (data phase)
- hready  output  1  slave hreadyout
- hresp  output  2  00 OKAY, 01 ERROR
- hrdata  output  DATA_WIDTH  read data (data phase)

Behaviour:
- Clocking: one clock hclk; reset hresetn is synchronous, active-low.
- Reset:
  - Sampled low at a posedge: state=IDLE, hready=1, hresp=00, hrdata=0, pending data phase discarded.
  - Memory contents are preserved.
  - Reset mid-transfer aborts without a memory write.
- Address phase accept: hsel & hready_in & htrans[1] at posedge. IDLE/BUSY or unselected leads to no data phase; slave stays at hready=1, OKAY.
- Decode at accept:
  - idx = (haddr-BASE_ADDR)>>2.
  - ERROR if haddr outside [BASE_ADDR, BASE_ADDR+4*MEM_DEPTH), hsize>3'b010, or misaligned (half: haddr[0]!=0; word: haddr[1:0]!=0).
- Byte enables, little-endian:
  - byte: lane haddr[1:0].
  - half: lanes {haddr[1],0} and {haddr[1],1}.
  - word: all four lanes.
- States:
  - IDLE: hready=1, hresp=00. Accept OKAY transfer goes to DATA with wcnt=WAIT_CYCLES (0 when feature off). Accept ERROR transfer goes to ERR1.
  - DATA:
    - wcnt!=0: hready=0, hresp=00, wcnt-1.
    - wcnt==0: hready=1, hresp=00, phase completes. A write commits hwdata lanes per byte enables at this edge.
    - On completion, a new accept in the same cycle goes to DATA or ERR1; otherwise IDLE.
  - ERR1: hready=0, hresp=01; always goes to ERR2.
  - ERR2: hready=1, hresp=01; no memory write. Accept in this cycle is handled as in IDLE.
- Read data:
  - hrdata is registered at accept with mem[idx] (full word, all lanes) and held until the next read accept.
  - Zero-wait reads therefore give valid data in the first data-phase cycle.
- Hazard: a read accepted in the same cycle a write data phase completes to the same idx returns the merged new word (write forwarding, lanes per byte enables).
- Back-to-back: zero-wait operation sustains one transfer per cycle.
- hwdata is sampled only in the completing data-phase cycle.
- htrans BUSY inside a burst: no data phase, OKAY.
- ERROR aborts only the erroneous transfer. Following transfers are accepted normally.

Optional Feature:
- AHB_SLV_WAIT_EN defined: every NONSEQ/SEQ data phase inserts WAIT_CYCLES cycles of hready=0 (OKAY) before completion.
- Undefined: wcnt logic removed, all OKAY transfers zero-wait, WAIT_CYCLES ignored.
- The ERROR response is always two cycles, regardless of the feature.

Test Plan:
- Reset then idle: hresetn=0 for 2 cycles -> hready=1, hresp=00, hrdata=0; htrans=IDLE for 5 cycles -> no change.
- Word write then read, feature off: write 0xDEADBEEF to 0x10, read 0x10 back-to-back -> forwarded hrdata=0xDEADBEEF in the read data phase, hready=1 each cycle.
- Sub-word writes: word 0x0 to 0x20; byte 0xAA at 0x21 (hsize=000); half 0x1234 at 0x22 -> read 0x20 returns 0x1234AA00.
- Errors:
  - haddr=BASE_ADDR+0x400 (MEM_DEPTH=256) -> hready 0 then 1 with hresp=01 both cycles; memory unchanged.
  - Word access at 0x02 -> same two-cycle ERROR.
- Waits, AHB_SLV_WAIT_EN with WAIT_CYCLES=2: read 0x10 -> hready low 2 cycles then high, hrdata=0xDEADBEEF.
- Reset mid-wait: hresetn low during the wait of a write to 0x30 -> IDLE, hready=1, mem[0x30] unchanged.
